// File: rtl/program_sequencer_if.sv
// program_sequencer_if: control inputs and status outputs of the program sequencer
interface program_sequencer_if #(
  parameter int ADDR_W      = 4,
  parameter int STACK_DEPTH = 4
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  logic              en;
  logic              jump;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] target;
  logic              clr_err;
  logic [ADDR_W-1:0] pc;
  logic [SP_W-1:0]   sp;
  logic              stk_empty;
  logic              stk_full;
  logic              ovf;
  logic              unf;
  modport master (
    output en, jump, call, ret, target, clr_err,
    input  pc, sp, stk_empty, stk_full, ovf, unf
  );
  modport slave (
    input  en, jump, call, ret, target, clr_err,
    output pc, sp, stk_empty, stk_full, ovf, unf
  );
endinterface

// File: rtl/program_sequencer.sv
// program_sequencer: program counter with a LIFO return stack and sticky overflow/underflow flags
module program_sequencer #(
  parameter int                ADDR_W      = 4,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input logic clk,
  input logic rst_n,
  program_sequencer_if.slave bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              push, empty, full;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  assign empty  = sp_q == '0;
  assign full   = sp_q == SP_W'(STACK_DEPTH);
  assign pc_inc = pc_q + 1'b1;
  assign wr_idx = sp_q[IDX_W-1:0];
  assign rd_idx = IDX_W'(sp_q - 1'b1);
  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    push  = 1'b0;
    ovf_d = bus.clr_err ? 1'b0 : ovf_q;
    unf_d = bus.clr_err ? 1'b0 : unf_q;
    if (bus.en) begin
      if (bus.ret) begin
        pc_d  = empty ? pc_inc : stack_q[rd_idx];
        sp_d  = empty ? sp_q : sp_q - 1'b1;
        unf_d = empty ? 1'b1 : unf_d;
      end else if (bus.call) begin
        pc_d  = bus.target;
        push  = !full;
        sp_d  = full ? sp_q : sp_q + 1'b1;
        ovf_d = full ? 1'b1 : ovf_d;
      end else begin
        pc_d = bus.jump ? bus.target : pc_inc;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_ADDR;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  // Stack contents need no reset: entries at or above sp are never read.
  always_ff @(posedge clk) begin
    if (push) stack_q[wr_idx] <= pc_inc;
  end
  assign bus.pc        = pc_q;
  assign bus.sp        = sp_q;
  assign bus.stk_empty = empty;
  assign bus.stk_full  = full;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;
endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter ADDR_W, default 4: width of the program address in bits.
REQ-002 Parameter STACK_DEPTH, default 4: number of return-stack entries, range 2..16.
REQ-003 Parameter RESET_ADDR, default 0: value loaded into pc on reset, ADDR_W bits.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  advance enable; 0 = stall, all state holds.
REQ-007 jump  input  1  load target into pc.
REQ-008 call  input  1  push pc+1 onto the return stack and load target into pc.
REQ-009 ret  input  1  pop the return stack into pc.
REQ-010 target  input  ADDR_W  absolute destination address for jump and call.
REQ-011 clr_err  input  1  clear the sticky error flags.
REQ-012 pc  output  ADDR_W  current program address, registered.
REQ-013 sp  output  $clog2(STACK_DEPTH+1)  number of valid stack entries, registered.
REQ-014 stk_empty  output  1  high when sp==0.
REQ-015 stk_full  output  1  high when sp==STACK_DEPTH.
REQ-016 ovf  output  1  sticky flag: a call was issued while the stack was full.
REQ-017 unf  output  1  sticky flag: a ret was issued while the stack was empty.

Function
REQ-018 Each edge with en=1 shall apply exactly one action, in priority order: ret, call, jump, increment.
REQ-019 Increment shall set pc to pc+1 modulo 2^ADDR_W, so all-ones wraps to 0.
REQ-020 jump shall set pc to target on the next edge (one-cycle latency); the stack is unchanged.
REQ-021 call with stk_full=0 shall write (pc+1) mod 2^ADDR_W to stack[sp], increment sp, and set pc to target in the same edge.
REQ-022 call with stk_full=1 shall set pc to target, leave the stack and sp unchanged, and set ovf.
REQ-023 ret with stk_empty=0 shall set pc to stack[sp-1] and decrement sp in the same edge.
REQ-024 ret with stk_empty=1 shall increment pc, leave sp at 0, and set unf.
REQ-025 When ret and call are both high, ret shall win; call and jump are ignored and no push occurs.
REQ-026 When call and jump are both high, call shall win.
REQ-027 When en=0, pc, sp, the stack contents and the flags shall hold, and all control inputs are ignored.
REQ-028 Exception: clr_err shall act regardless of en.
REQ-029 On a clr_err edge, ovf and unf shall go to 0.
REQ-030 If a new error event and clr_err occur on the same edge, the flag shall end at 1 (set wins).
REQ-031 stk_empty and stk_full shall be combinational decodes of the registered sp.
REQ-032 The stack shall be a register array indexed by sp (LIFO), not a FIFO.
REQ-033 Entries at or above sp are don't-care and shall never be driven onto pc.
REQ-034 A nesting depth of exactly STACK_DEPTH calls, followed by STACK_DEPTH rets, shall restore every return address without error.

Reset
REQ-035 While rst_n=0, independent of clk: pc=RESET_ADDR, sp=0, ovf=0, unf=0, stk_empty=1, stk_full=0.
REQ-036 Reset shall not be required to clear stack contents.
REQ-037 Reset asserted mid-operation shall abort any in-flight action; no partial push or pop shall survive.
REQ-038 The first edge after rst_n rises shall process the inputs normally.

Verification
REQ-039 Reset, en=1, no controls, ADDR_W=4 -> pc steps 0,1,...,15,0 (wrap), sp stays 0.
REQ-040 pc=3, call with target=9 -> pc=9, sp=1; next edge ret -> pc=4, sp=0, no flags.
REQ-041 STACK_DEPTH=4: five consecutive calls from pc=0, each with target=8 -> sp=4, stk_full=1, ovf=1 after the fifth; four rets then return pc to 9,9,9,1.
REQ-042 ret with sp=0 at pc=6 -> pc=7, unf=1; pulse clr_err with en=0 -> unf=0, pc still 7.
REQ-043 pc=2, sp=1, ret+call+jump all high with en=1 -> ret wins (pc = popped value, sp=0, no push); repeat with en=0 -> no change.
REQ-044 Assert rst_n=0 asynchronously between edges during a call sequence with sp=2 -> pc=RESET_ADDR and sp=0 immediately, without waiting for an edge.
